multu_arbiter: RTL and testbench

//  Shares one sequential multu unit (32x32 unsigned shift-add) between NREQ requesters.

---
 rtl/multu_arbiter_pkg.sv | 14 +
 rtl/multu_arbiter_rr_pick.sv | 32 +++
 rtl/multu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_multu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multu_arbiter_pkg.sv
// Shared definitions for the multu arbiter: FSM state encoding and default datapath widths.
package multu_arbiter_pkg;

  localparam int unsigned MultW = 32;
  localparam int unsigned ProdW = 2 * MultW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StResp = 2'd3
  } state_e;

endpackage

// File: rtl/multu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping to 0.
module multu_arbiter_rr_pick #(
  parameter int unsigned NReq = 2,
  parameter int unsigned IdW  = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NReq-1:0] onehot_o,
  output logic [IdW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned off;
    int unsigned best;
    off   = 0;
    best  = 0;
    idx_o = '0;
    any_o = 1'b0;
    // Distance from the pointer decides priority; smallest wrapped distance wins.
    for (int unsigned i = 0; i < NReq; i++) begin
      off = (i >= 32'(ptr_i)) ? i - 32'(ptr_i) : i + NReq - 32'(ptr_i);
      if (req_i[i] && (!any_o || off < best)) begin
        best  = off;
        idx_o = IdW'(i);
        any_o = 1'b1;
      end
    end
    onehot_o = any_o ? (NReq'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/multu_arbiter.sv
// Shares one sequential multiplier between NREQ requesters with round-robin grant,
// operand latching, a completion watchdog and a tagged, registered result strobe.
module multu_arbiter
  import multu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = MultW,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned IdW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] a_in_i,
  input  logic [NREQ*WIDTH-1:0] b_in_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]      mul_a_o,
  output logic [WIDTH-1:0]      mul_b_o,
  output logic                  mul_start_o,
  output logic                  mul_abort_o,
  input  logic                  mul_done_i,
  input  logic [2*WIDTH-1:0]    mul_prod_i,
  output logic                  res_valid_o,
  output logic [IdW-1:0]        res_id_o,
  output logic [2*WIDTH-1:0]    res_prod_o,
  output logic                  res_err_o,
  output logic                  busy_o
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     win_q, win_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               mul_start_q, mul_start_d;
  logic               mul_abort_q, mul_abort_d;
  logic               res_valid_q, res_valid_d;
  logic [IdW-1:0]     res_id_q, res_id_d;
  logic [2*WIDTH-1:0] res_prod_q, res_prod_d;
  logic               res_err_q, res_err_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [IdW-1:0]     pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   a_sel, b_sel;

  multu_arbiter_rr_pick #(
    .NReq (NREQ),
    .IdW  (IdW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) begin
        a_sel = a_in_i[i*WIDTH +: WIDTH];
        b_sel = b_in_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    wd_d        = wd_q;
    gnt_d       = '0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    mul_abort_d = 1'b0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_prod_d  = res_prod_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          win_d   = pick_idx;
          mul_a_d = a_sel;
          mul_b_d = b_sel;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mul_start_d = 1'b1;
        wd_d        = '0;
        state_d     = StRun;
      end
      StRun: begin
        wd_d = wd_q + WdW'(1);
        // Completion takes priority over a timeout landing on the same edge.
        if (mul_done_i) begin
          res_prod_d = mul_prod_i;
          res_err_d  = 1'b0;
          state_d    = StResp;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          res_prod_d  = '0;
          res_err_d   = 1'b1;
          mul_abort_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        res_valid_d = 1'b1;
        res_id_d    = win_q;
        rr_ptr_d    = (win_q == IdW'(NREQ - 1)) ? '0 : win_q + IdW'(1);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_abort_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_prod_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      mul_abort_q <= mul_abort_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_prod_q  <= res_prod_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_start_o = mul_start_q;
  assign mul_abort_o = mul_abort_q;
  assign res_valid_o = res_valid_q;
  assign res_id_o    = res_id_q;
  assign res_prod_o  = res_prod_q;
  assign res_err_o   = res_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_multu_arbiter.sv
// Bench for multu_arbiter: transaction-timeline reference model, per-cycle compare, directed
// scenarios with literal expectations and a randomized soak.
module tb_multu_arbiter;
  import multu_arbiter_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned WIDTH   = MultW;
  localparam int unsigned PW      = ProdW;
  localparam int unsigned TIMEOUT = 40;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic                  mul_start, mul_abort;
  logic                  mul_done = 1'b0;
  logic [PW-1:0]         mul_prod = '0;
  logic                  res_valid;
  logic [0:0]            res_id;
  logic [PW-1:0]         res_prod;
  logic                  res_err, busy;

  always #5 clk = ~clk;

  multu_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .req_i       (req),
    .a_in_i      (a_in),
    .b_in_i      (b_in),
    .gnt_o       (gnt),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_start_o (mul_start),
    .mul_abort_o (mul_abort),
    .mul_done_i  (mul_done),
    .mul_prod_i  (mul_prod),
    .res_valid_o (res_valid),
    .res_id_o    (res_id),
    .res_prod_o  (res_prod),
    .res_err_o   (res_err),
    .busy_o      (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stimulus knobs
  logic [WIDTH-1:0] a_v [NREQ];
  logic [WIDTH-1:0] b_v [NREQ];
  int  done_lat   = 0;   // >=0: done that many RUN edges after start; <0: random
  int  done_pct   = 0;
  bit  force_done = 1'b0;

  // Reference model: one operation tracked as a timeline anchored at its grant edge
  longint unsigned  cyc = 0;
  bit               m_active = 1'b0;
  bit               m_ended  = 1'b0;
  longint unsigned  m_t = 0;
  longint unsigned  m_e = 0;
  int               m_win = 0;
  int               m_ptr = 0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [PW-1:0]    m_prod = '0;

  logic [NREQ-1:0]  e_gnt = '0;
  logic             e_start = 0, e_abort = 0, e_valid = 0, e_err = 0, e_busy = 0;
  logic [PW-1:0]    e_prod = '0;
  int               e_id = 0;
  logic [WIDTH-1:0] e_a = '0, e_b = '0;

  // Observations of the DUT used by the directed literal checks
  int               n_results = 0, n_gnt = 0, n_start = 0;
  longint unsigned  start_cyc = 0, abort_cyc = 0;
  logic [PW-1:0]    got_prod = '0;
  int               got_id = 0;
  logic             got_err = 0;

  function automatic void model_clear();
    m_active = 0; m_ended = 0; m_ptr = 0;
    e_gnt = '0; e_start = 0; e_abort = 0; e_valid = 0; e_busy = 0;
    e_a = '0; e_b = '0;
  endfunction

  function automatic void model_edge();
    bit found;
    e_gnt = '0; e_start = 0; e_abort = 0; e_valid = 0;
    found = 0;
    if (!m_active) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && req[c]) begin
          found = 1;
          m_win = c;
        end
      end
      if (found) begin
        m_active = 1; m_ended = 0; m_t = cyc;
        m_a = a_in[m_win*WIDTH +: WIDTH];
        m_b = b_in[m_win*WIDTH +: WIDTH];
        e_gnt[m_win] = 1'b1;
        e_a = m_a; e_b = m_b;
      end
    end else if (cyc == m_t + 1) begin
      e_start = 1;
    end else if (!m_ended) begin
      if (mul_done) begin
        m_ended = 1; m_e = cyc; m_err = 0; m_prod = mul_prod;
      end else if (cyc - m_t - 1 == longint'(TIMEOUT)) begin
        m_ended = 1; m_e = cyc; m_err = 1; m_prod = '0; e_abort = 1;
      end
    end else begin
      e_valid = 1; e_id = m_win; e_err = m_err; e_prod = m_prod;
      m_ptr = (m_win + 1) % NREQ;
      m_active = 0;
    end
    e_busy = m_active;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("mul_start", 64'(mul_start), 64'(e_start));
      chk("mul_abort", 64'(mul_abort), 64'(e_abort));
      chk("res_valid", 64'(res_valid), 64'(e_valid));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("mul_a", 64'(mul_a), 64'(e_a));
      chk("mul_b", 64'(mul_b), 64'(e_b));
      if (e_valid) begin
        chk("res_id", 64'(res_id), 64'(e_id));
        chk("res_err", 64'(res_err), 64'(e_err));
        chk("res_prod", res_prod, e_prod);
      end
      if (|gnt) n_gnt++;
      if (mul_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (mul_abort) abort_cyc = cyc;
      if (res_valid) begin
        n_results++;
        got_prod = res_prod; got_id = int'(res_id); got_err = res_err;
      end
    end
  end

  task automatic step();
    for (int k = 0; k < NREQ; k++) begin
      a_in[k*WIDTH +: WIDTH] = a_v[k];
      b_in[k*WIDTH +: WIDTH] = b_v[k];
    end
    if (force_done) mul_done = 1'b1;
    else if (done_lat >= 0)
      mul_done = m_active && !m_ended && (cyc + 1 == m_t + 2 + longint'(done_lat));
    else mul_done = ($urandom_range(0, 99) < done_pct);
    mul_prod = m_active ? {32'h0, m_a} * {32'h0, m_b} : {$urandom, $urandom};
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    mul_done = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_start_abort", 64'({mul_start, mul_abort}), 64'd0);
    chk("rst_res", 64'({res_valid, res_err, res_id}), 64'd0);
    chk("rst_prod", res_prod, 64'd0);
    chk("rst_ops", 64'({mul_a, mul_b}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    model_clear();
    n_gnt = 0; n_start = 0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_until_result(input bit hold_req, input int budget);
    int start_n;
    start_n = n_results;
    for (int i = 0; i < budget && n_results == start_n; i++) begin
      step();
      if (!hold_req && m_active) req = '0;
    end
    chk("result_arrived", 64'(n_results - start_n), 64'd1);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    do_reset();

    // 1: single op
    a_v[0] = 32'd3; b_v[0] = 32'd5; req = 2'b01; done_lat = 3;
    run_until_result(1'b0, 100);
    chk("t1_prod", got_prod, 64'd15);
    chk("t1_id", 64'(got_id), 64'd0);
    chk("t1_err", 64'(got_err), 64'd0);
    chk("t1_gnt_count", 64'(n_gnt), 64'd1);
    chk("t1_start_count", 64'(n_start), 64'd1);

    // 2: max operands
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF; req = 2'b01; done_lat = 5;
    run_until_result(1'b0, 100);
    chk("t2_prod", got_prod, 64'hFFFF_FFFE_0000_0001);

    // 3: fairness with both requesters held
    do_reset();
    a_v[0] = 32'd10; b_v[0] = 32'd11; a_v[1] = 32'd12; b_v[1] = 32'd13;
    req = 2'b11; done_lat = 2;
    for (int n = 0; n < 4; n++) begin
      run_until_result(1'b1, 100);
      chk("t3_id_seq", 64'(got_id), 64'(n % 2));
    end
    req = '0;
    step();

    // 4: hung multiplier, then the next request is served
    done_lat = 1000; req = 2'b01;
    run_until_result(1'b0, 100);
    chk("t4_err", 64'(got_err), 64'd1);
    chk("t4_prod", got_prod, 64'd0);
    chk("t4_abort_delay", abort_cyc - start_cyc, 64'd40);
    req = 2'b10; done_lat = 1;
    run_until_result(1'b0, 100);
    chk("t4_next_id", 64'(got_id), 64'd1);
    chk("t4_next_err", 64'(got_err), 64'd0);

    // 5: reset in RUN; pointer returns to 0
    req = 2'b01; done_lat = 0;
    run_until_result(1'b0, 100);
    req = 2'b10; done_lat = 1000;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_active) req = '0;
    end
    begin
      int n0;
      n0 = n_results;
      do_reset();
      for (int i = 0; i < 6; i++) step();
      chk("t5_no_result", 64'(n_results - n0), 64'd0);
    end
    req = 2'b11; done_lat = 2;
    run_until_result(1'b0, 100);
    chk("t5_ptr_zero_id", 64'(got_id), 64'd0);

    // 6: spurious done in IDLE and LOAD is ignored
    begin
      int n0;
      n0 = n_results;
      req = '0; force_done = 1'b1;
      for (int i = 0; i < 3; i++) step();
      a_v[1] = 32'd7; b_v[1] = 32'd6; req = 2'b10;
      step();
      req = '0;
      step();
      force_done = 1'b0;
      chk("t6_no_spurious", 64'(n_results - n0), 64'd0);
    end
    done_lat = 4;
    run_until_result(1'b0, 100);
    chk("t6_prod", got_prod, 64'd42);
    chk("t6_id", 64'(got_id), 64'd1);

    // Randomized soak; random done also lands outside RUN and sometimes never in time
    do_reset();
    done_lat = -1; done_pct = 6;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        a_v[k] = $urandom;
        b_v[k] = $urandom;
      end
      req = NREQ'($urandom_range(0, 3));
      if (i == 2000) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
